// File: rtl/dice_pkg.sv
// Shared types and constants for the PE configuration controller.
package dice_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_ARMED = 2'd2,
        ST_RUN   = 2'd3
    } state_e;

    localparam int unsigned CFG_W       = 32;
    localparam int unsigned PKT_WORDS   = 3;
    localparam int unsigned OUT_SEL_BIT = 0;
    localparam int unsigned NSTEPS_LSB  = 8;
    localparam int unsigned NSTEPS_W    = 4;
    localparam int unsigned STEP_W      = 5;

    // Saturate a requested schedule depth at the instance maximum.
    function automatic logic [STEP_W-1:0] clamp_steps(input logic [NSTEPS_W-1:0] n,
                                                      input int unsigned max_steps);
        if (32'(n) > max_steps) begin
            return STEP_W'(max_steps);
        end
        return STEP_W'(n);
    endfunction

endpackage

// File: rtl/dice_pe_ctrl.sv
// Loads a 3-word configuration packet, then replays a per-cycle DFF schedule
// into one PE on start.
module dice_pe_ctrl
    import dice_pkg::*;
#(
    parameter int unsigned MAX_STEPS = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CFG_W-1:0] cfg_data,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [CFG_W-1:0] opcode,
    output logic             out_sel,
    output logic             dff_input_mode,
    output logic             dff_latch_enable
);

    localparam int unsigned SCHED_W = 2 * MAX_STEPS;

    state_e                state_q, state_d;
    logic [1:0]            wcnt_q, wcnt_d;
    logic [STEP_W-1:0]     step_q, step_d;
    logic [STEP_W-1:0]     nsteps_q, nsteps_d;
    logic [SCHED_W-1:0]    sched_q, sched_d;
    logic [CFG_W-1:0]      sh_op_q, sh_op_d;
    logic                  sh_out_sel_q, sh_out_sel_d;
    logic [NSTEPS_W-1:0]   sh_nsteps_q, sh_nsteps_d;
    logic [CFG_W-1:0]      opcode_q, opcode_d;
    logic                  out_sel_q, out_sel_d;
    logic                  done_q, done_d;
    logic                  im_q, im_d;

    logic                  cfg_fire_c;
    logic                  run_c;
    logic                  last_c;
    logic [1:0]            pair_c;

    assign run_c      = (state_q == ST_RUN);
    assign cfg_fire_c = cfg_valid && !run_c;
    assign pair_c     = 2'(sched_q >> {step_q, 1'b0});
    assign last_c     = (step_q == nsteps_q - STEP_W'(1));

    // State and configuration registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            wcnt_q       <= '0;
            step_q       <= '0;
            nsteps_q     <= '0;
            sched_q      <= '0;
            sh_op_q      <= '0;
            sh_out_sel_q <= 1'b0;
            sh_nsteps_q  <= '0;
            opcode_q     <= '0;
            out_sel_q    <= 1'b0;
            done_q       <= 1'b0;
            im_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            wcnt_q       <= wcnt_d;
            step_q       <= step_d;
            nsteps_q     <= nsteps_d;
            sched_q      <= sched_d;
            sh_op_q      <= sh_op_d;
            sh_out_sel_q <= sh_out_sel_d;
            sh_nsteps_q  <= sh_nsteps_d;
            opcode_q     <= opcode_d;
            out_sel_q    <= out_sel_d;
            done_q       <= done_d;
            im_q         <= im_d;
        end
    end

    // Next-state: packet loading, commit and schedule stepping.
    always_comb begin
        state_d      = state_q;
        wcnt_d       = wcnt_q;
        step_d       = step_q;
        nsteps_d     = nsteps_q;
        sched_d      = sched_q;
        sh_op_d      = sh_op_q;
        sh_out_sel_d = sh_out_sel_q;
        sh_nsteps_d  = sh_nsteps_q;
        opcode_d     = opcode_q;
        out_sel_d    = out_sel_q;
        done_d       = 1'b0;
        im_d         = im_q;

        case (state_q)
            ST_IDLE, ST_ARMED: begin
                // A new packet takes precedence over a coincident start.
                if (cfg_fire_c) begin
                    state_d = ST_LOAD;
                    sh_op_d = cfg_data;
                    wcnt_d  = 2'd1;
                end else if (state_q == ST_ARMED && start) begin
                    step_d = '0;
                    if (nsteps_q == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_LOAD: begin
                if (cfg_fire_c) begin
                    if (wcnt_q == 2'(PKT_WORDS - 1)) begin
                        state_d   = ST_ARMED;
                        wcnt_d    = '0;
                        opcode_d  = sh_op_q;
                        out_sel_d = sh_out_sel_q;
                        nsteps_d  = clamp_steps(sh_nsteps_q, MAX_STEPS);
                        sched_d   = cfg_data[SCHED_W-1:0];
                    end else begin
                        wcnt_d       = wcnt_q + 2'd1;
                        sh_out_sel_d = cfg_data[OUT_SEL_BIT];
                        sh_nsteps_d  = cfg_data[NSTEPS_LSB +: NSTEPS_W];
                    end
                end
            end
            ST_RUN: begin
                im_d = pair_c[0];
                if (last_c) begin
                    state_d = ST_ARMED;
                    step_d  = '0;
                    done_d  = 1'b1;
                end else begin
                    step_d = step_q + STEP_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // DFF controls follow the current step live; input mode holds once the run ends.
    assign dff_latch_enable = run_c && pair_c[1];
    assign dff_input_mode   = run_c ? pair_c[0] : im_q;
    assign busy             = run_c;
    assign cfg_ready        = !run_c;
    assign done             = done_q;
    assign opcode           = opcode_q;
    assign out_sel          = out_sel_q;

endmodule

// File: tb/tb_dice_pe_ctrl.sv
// Directed bench for dice_pe_ctrl: expected per-cycle run behaviour is queued
// when start is driven and compared as the DUT steps through the schedule.
module tb_dice_pe_ctrl;

    localparam int unsigned MAX_STEPS = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [31:0] cfg_data;
    logic        start;
    logic        busy;
    logic        done;
    logic [31:0] opcode;
    logic        out_sel;
    logic        dff_input_mode;
    logic        dff_latch_enable;

    dice_pe_ctrl #(.MAX_STEPS(MAX_STEPS)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .cfg_valid        (cfg_valid),
        .cfg_ready        (cfg_ready),
        .cfg_data         (cfg_data),
        .start            (start),
        .busy             (busy),
        .done             (done),
        .opcode           (opcode),
        .out_sel          (out_sel),
        .dff_input_mode   (dff_input_mode),
        .dff_latch_enable (dff_latch_enable)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic busy;
        logic le;
        logic im;
        logic done;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    logic im_model = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One config word, one cycle; DUT is never in RUN when this is called.
    task automatic send(input logic [31:0] w);
        cfg_valid = 1'b1;
        cfg_data  = w;
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic push_run(input logic [31:0] s, input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e.busy = 1'b1;
            e.le   = s[2*k+1];
            e.im   = s[2*k];
            e.done = 1'b0;
            im_model = s[2*k];
            sb.push_back(e);
        end
        e.busy = 1'b0;
        e.le   = 1'b0;
        e.im   = im_model;
        e.done = 1'b1;
        sb.push_back(e);
    endtask

    task automatic check_entry(input string tag, input exp_t e);
        chk({tag, "_busy"},  32'(busy),             32'(e.busy));
        chk({tag, "_le"},    32'(dff_latch_enable), 32'(e.le));
        chk({tag, "_im"},    32'(dff_input_mode),   32'(e.im));
        chk({tag, "_done"},  32'(done),             32'(e.done));
        chk({tag, "_ready"}, 32'(cfg_ready),        32'(!e.busy));
    endtask

    task automatic start_and_drain(input string tag);
        exp_t e;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check_entry(tag, e);
            @(negedge clk);
        end
        chk({tag, "_done_one_cycle"}, 32'(done), 32'd0);
        chk({tag, "_le_idle"}, 32'(dff_latch_enable), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: run did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        rst_n     = 1'b0;
        cfg_valid = 1'b0;
        cfg_data  = '0;
        start     = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        chk("rst_busy",      32'(busy), 32'd0);
        chk("rst_opcode",    opcode, 32'd0);
        chk("rst_le",        32'(dff_latch_enable), 32'd0);
        chk("rst_im",        32'(dff_input_mode), 32'd0);
        chk("rst_out_sel",   32'(out_sel), 32'd0);
        chk("rst_done",      32'(done), 32'd0);

        // start in IDLE must not run anything
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) begin
            chk("idle_start_busy", 32'(busy), 32'd0);
            chk("idle_start_done", 32'(done), 32'd0);
            @(negedge clk);
        end

        // basic load and 3-step run
        send(32'h0000_0005);
        chk("load_w0_opcode", opcode, 32'd0);
        send(32'h0000_0301);
        chk("load_w1_opcode", opcode, 32'd0);
        chk("load_w1_out_sel", 32'(out_sel), 32'd0);
        send(32'h0000_0023);
        chk("commit_opcode",  opcode, 32'd5);
        chk("commit_out_sel", 32'(out_sel), 32'd1);
        push_run(32'h0000_0023, 3);
        start_and_drain("run3");

        // stalled packet in ARMED: active config must not move until W2
        send(32'hA5A5_0007);
        chk("stall0_opcode", opcode, 32'd5);
        @(negedge clk);
        chk("stall1_opcode", opcode, 32'd5);
        send(32'h0000_0F00);
        chk("stall2_opcode", opcode, 32'd5);
        chk("stall2_out_sel", 32'(out_sel), 32'd1);
        @(negedge clk);
        chk("stall3_opcode", opcode, 32'd5);
        send(32'h0000_9C63);
        chk("stall_commit_opcode",  opcode, 32'hA5A5_0007);
        chk("stall_commit_out_sel", 32'(out_sel), 32'd0);

        // num_steps=15 saturates at MAX_STEPS
        push_run(32'h0000_9C63, MAX_STEPS);
        start_and_drain("clamp");

        // zero-length schedule: done only
        send(32'h0000_1234);
        send(32'h0000_0001);
        send(32'h0000_FFFF);
        chk("zero_commit_opcode", opcode, 32'h0000_1234);
        push_run(32'h0000_FFFF, 0);
        start_and_drain("zero");

        // reset during RUN at step 2
        send(32'h0000_0077);
        send(32'h0000_0800);
        send(32'h0000_FFFF);
        push_run(32'h0000_FFFF, 8);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            e = sb.pop_front();
            check_entry("midrun", e);
            if (i < 2) @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        sb.delete();
        im_model = 1'b0;
        chk("midrst_busy",   32'(busy), 32'd0);
        chk("midrst_le",     32'(dff_latch_enable), 32'd0);
        chk("midrst_ready",  32'(cfg_ready), 32'd1);
        chk("midrst_opcode", opcode, 32'd0);
        chk("midrst_im",     32'(dff_input_mode), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) begin
            chk("post_rst_busy", 32'(busy), 32'd0);
            chk("post_rst_done", 32'(done), 32'd0);
            chk("post_rst_le",   32'(dff_latch_enable), 32'd0);
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dice_pe_ctrl.md
DICE_PE_CTRL -- requirements
Module: dice_pe_ctrl

Interface
REQ-001 SHALL have parameter MAX_STEPS, default 8, meaning the maximum schedule depth in cycles (1..16).
REQ-002 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port cfg_valid  input  1  config word valid.
REQ-005 SHALL have port cfg_ready  output  1  config word accepted when cfg_valid && cfg_ready.
REQ-006 SHALL have port cfg_data  input  32  config word.
REQ-007 SHALL have port start  input  1  request to run the committed schedule.
REQ-008 SHALL have port busy  output  1  high while in RUN.
REQ-009 SHALL have port done  output  1  one-cycle pulse at schedule completion.
REQ-010 SHALL have port opcode  output  32  static PE opcode.
REQ-011 SHALL have port out_sel  output  1  static PE output select.
REQ-012 SHALL have port dff_input_mode  output  1  dynamic PE DFF routing.
REQ-013 SHALL have port dff_latch_enable  output  1  dynamic PE DFF latch enable.

Function
REQ-014 SHALL implement FSM states IDLE (unconfigured), LOAD, ARMED, RUN.
REQ-015 SHALL drive cfg_ready=1 in IDLE, LOAD and ARMED, and cfg_ready=0 in RUN.
REQ-016 SHALL accept a config packet of exactly 3 words: W0=opcode; W1[0]=out_sel, W1[11:8]=num_steps; W2[2*MAX_STEPS-1:0]=schedule, with step k as {latch_en=bit 2k+1, input_mode=bit 2k}.
REQ-017 SHALL move IDLE/ARMED->LOAD on the W0 handshake, count words 0..2 in LOAD, and move LOAD->ARMED on the W2 handshake.
REQ-018 SHALL hold packet words in shadow registers and commit all of them to the active registers in the W2 handshake cycle; opcode/out_sel SHALL change only at commit.
REQ-019 SHALL clamp num_steps greater than MAX_STEPS to MAX_STEPS, and SHALL treat num_steps=0 as a zero-length run.
REQ-020 SHALL ignore start in IDLE, LOAD and RUN.
REQ-021 SHALL, on start in ARMED, enter RUN on the next edge with step=0.
REQ-022 SHALL, in RUN, drive dff_latch_enable and dff_input_mode combinationally from schedule step `step`, and SHALL increment step each cycle.
REQ-023 SHALL, in the cycle of the last step (step=num_steps-1), return to ARMED on the next edge and pulse done=1 for exactly that next cycle.
REQ-024 SHALL, for num_steps=0, go ARMED->ARMED on start with done pulsed the following cycle and no latch_enable asserted.
REQ-025 SHALL force dff_latch_enable=0 outside RUN; dff_input_mode SHALL hold its last driven value outside RUN.
REQ-026 SHALL accept a new packet in ARMED without disturbing the active config until commit; start during LOAD SHALL be ignored.
REQ-027 SHALL keep busy equal to (state==RUN).

Reset
REQ-028 SHALL, on rst_n low, asynchronously set state=IDLE, step=0, word count=0, opcode=0, out_sel=0, dff_input_mode=0, dff_latch_enable=0, done=0, busy=0, and clear both schedules.
REQ-029 SHALL, on reset asserted mid-LOAD or mid-RUN, discard the partial packet or run and require a full reload before a run.

Structure
REQ-030 SHALL place the FSM state enum, the config word field offsets and the 3-word packet length constant in the shared package dice_pkg.
REQ-031 SHALL be a single module with no sub-modules; its outputs connect directly to the matching configuration inputs of one PE.

Verification
REQ-032 SHALL verify reset: after rst_n low, then high, cfg_ready=1, busy=0, opcode=0, dff_latch_enable=0.
REQ-033 SHALL verify load-and-run: W0=0x0000_0005, W1=0x0000_0301, W2=0x0000_0023 then start -> opcode=5, out_sel=1, busy for 3 cycles with (le,im)=(1,1),(0,0),(1,0), then done pulse.
REQ-034 SHALL verify stall: cfg_valid toggling 1/0 per cycle -> commit only after the third handshake; opcode unchanged before commit.
REQ-035 SHALL verify clamp: num_steps=15 with MAX_STEPS=8 -> exactly 8 busy cycles, then one done pulse.
REQ-036 SHALL verify start ignored in IDLE, start with num_steps=0 (done only, no latch_enable), and cfg_ready=0 during RUN.
REQ-037 SHALL verify mid-run reset: rst_n low at step 2 -> state IDLE, and a subsequent start produces no busy.
